// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory-port round-robin arbiter.
// The optional grant timeout is enabled with the ARB_TIMEOUT_EN macro,
// which is consumed by mem_port_arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest requester count the shared-port muxes support (mux8).
  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  // One-hot encode idx into an ARB_MAX_REQ-wide vector; bits at or above n stay 0.
  function automatic logic [ARB_MAX_REQ-1:0] onehot(input logic [ARB_IDX_W-1:0] idx,
                                                    input int n);
    logic [ARB_MAX_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if ((i < n) && (idx == ARB_IDX_W'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so the slot after last_ptr sits
// at bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int SELW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last_ptr,
  output logic [SELW-1:0] winner,
  output logic            any_req
);

  logic [SELW-1:0] start;
  logic [NREQ-1:0] rot;
  logic [SELW-1:0] off;

  // NREQ is a power of two, so SELW-bit arithmetic wraps modulo NREQ for free.
  assign start   = last_ptr + SELW'(1);
  assign any_req = |req;

  // Rotate, find the lowest set bit, rotate back.
  // NOTE: every variable assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[start + SELW'(i)];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    winner = start + off;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ requesters.
// A grant is held for a whole access until mem_done, then one IDLE cycle
// follows before the next grant. Defining ARB_TIMEOUT_EN adds a counter that
// forcibly releases a grant after TIMEOUT cycles and pulses err_timeout.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  localparam int SELW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            mem_valid,
  input  logic            mem_done,
  output logic            busy,
  output logic            err_timeout
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] last_ptr_q, last_ptr_d;
  logic [SELW-1:0] winner;
  logic            any_req;

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = 16;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .winner   (winner),
    .any_req  (any_req)
  );

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    last_ptr_d = last_ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = NREQ'(onehot(ARB_IDX_W'(winner), NREQ));
          sel_d   = winner;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Request changes are ignored here; only completion ends the access.
        if (mem_done) begin
          state_d    = IDLE;
          gnt_d      = '0;
          valid_d    = 1'b0;
          last_ptr_d = sel_q;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          gnt_d      = '0;
          valid_d    = 1'b0;
          last_ptr_d = sel_q;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      last_ptr_q <= SELW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      last_ptr_q <= last_ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign mem_valid = valid_q;
  assign busy      = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NREQ=4, TIMEOUT=10).
// The timeout scenario follows ARB_TIMEOUT_EN when defined; otherwise it checks
// that a grant is held indefinitely.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       mem_valid;
  logic       mem_done;
  logic       busy;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.NREQ(4), .TIMEOUT(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .sel         (sel),
    .mem_valid   (mem_valid),
    .mem_done    (mem_done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic e);
    check({tag, ".gnt"},  {28'd0, gnt},         {28'd0, g});
    check({tag, ".sel"},  {30'd0, sel},         {30'd0, s});
    check({tag, ".valid"}, {31'd0, mem_valid},  {31'd0, v});
    check({tag, ".busy"}, {31'd0, busy},        {31'd0, v});
    check({tag, ".err"},  {31'd0, err_timeout}, {31'd0, e});
  endtask

  // Grant to idx is currently visible: hold one cycle, complete, check the IDLE gap.
  task automatic do_access(input string tag, input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'd1 << idx;
    check_out({tag, ".grant"}, oh, idx, 1'b1, 1'b0);
    tick();
    check_out({tag, ".hold"}, oh, idx, 1'b1, 1'b0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_out({tag, ".gap"}, 4'b0000, idx, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2; rr_seq[3] = 2'd3; rr_seq[4] = 2'd0;

    // Reset state
    rst_n = 1'b0; req = 4'b0000; mem_done = 1'b0;
    tick(); tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Round robin with all requesting: 0,1,2,3,0 with one IDLE cycle between
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      do_access($sformatf("rr%0d", i), rr_seq[i]);
      if (i == 4) req = 4'b0000;
      tick();
    end
    check_out("rr_end_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2, held for several cycles, then released
    req = 4'b0100;
    tick();
    check_out("r2.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); tick();
    check_out("r2.held", 4'b0100, 2'd2, 1'b1, 1'b0);
    mem_done = 1'b1; req = 4'b0000;
    tick();
    mem_done = 1'b0;
    check_out("r2.release", 4'b0000, 2'd2, 1'b0, 1'b0);

    // mem_done while IDLE is ignored
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_out("idle_done", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    check_out("idle_done2", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Grant to 1; dropping req[1] and raising req[3] changes nothing until done
    req = 4'b0010;
    tick();
    check_out("swap.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    check_out("swap.ign1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    check_out("swap.ign2", 4'b0010, 2'd1, 1'b1, 1'b0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_out("swap.gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    check_out("swap.next", 4'b1000, 2'd3, 1'b1, 1'b0);
    mem_done = 1'b1; req = 4'b0000;
    tick();
    mem_done = 1'b0;

    // Reset in the middle of a grant; priority returns to requester 0
    req = 4'b0100;
    tick();
    check_out("mid_rst.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_out("mid_rst.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1; req = 4'b1111;
    tick();
    check_out("mid_rst.first", 4'b0001, 2'd0, 1'b1, 1'b0);
    mem_done = 1'b1; req = 4'b0001;
    tick();
    mem_done = 1'b0;

    // Lone requester is re-granted after a single IDLE cycle
    check_out("regrant.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("regrant.again", 4'b0001, 2'd0, 1'b1, 1'b0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_out("regrant.gap2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Forced release after TIMEOUT=10 grant cycles
    check_out("to.grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick();
      check_out($sformatf("to.hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("to.release", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check_out("to.pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // mem_done on the timeout cycle wins: no error pulse
    req = 4'b0001;
    tick();
    check_out("to_done.grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) tick();
    mem_done = 1'b1; req = 4'b0000;
    tick();
    mem_done = 1'b0;
    check_out("to_done.release", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // Without the timeout the grant is held indefinitely
    for (int i = 0; i < 60; i++) begin
      check_out($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
      tick();
    end
    mem_done = 1'b1; req = 4'b0000;
    tick();
    mem_done = 1'b0;
    check_out("hold.release", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one memory/datapath port between NREQ requesters (e.g. instruction fetch, data load/store, DMA).
- Drives the select input of the existing mux2/mux4/mux8 that steer address/wdata onto the shared port, and the one-hot grant back to the requesters.
- Holds each grant for a whole access, until the slave acknowledges it.
- Sits between the pipeline stage controllers and the memory interface.

Parameters:
- NREQ, 4, number of requesters; legal values 2, 4, 8 (these match the mux2/mux4/mux8 widths).
- SELW, $clog2(NREQ), width of the select output; derived, never overridden.
- TIMEOUT, 255, maximum cycles a grant may stay open without mem_done. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- req  in  NREQ  request level per requester; bit i = requester i.
- gnt  out  NREQ  one-hot grant; all zero when idle.
- sel  out  SELW  binary index of the granted requester; drives the mux signal input.
- mem_valid  out  1  access-in-progress strobe to the slave; high throughout GRANT.
- mem_done  in  1  slave completion, single-cycle pulse.
- busy  out  1  high while in GRANT.
- err_timeout  out  1  one-cycle pulse when a grant is forcibly released. Tied 0 when the feature is off.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE.
  - gnt=0, sel=0, mem_valid=0, busy=0, err_timeout=0.
  - last_ptr=NREQ-1, so requester 0 has top priority after reset.
  - timeout counter=0.
  - Reset mid-access abandons the grant immediately. No done event is generated.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit scanning upward from last_ptr+1, wrapping modulo NREQ.
  - Next cycle: state=GRANT; gnt=onehot(winner), sel=winner, mem_valid=1, busy=1.
  - If req==0, stay in IDLE with outputs at 0. sel holds its last value.
- GRANT:
  - gnt, sel and mem_valid are stable.
  - req changes, including deassertion by the granted requester, are ignored until release.
- Release on mem_done=1 in GRANT:
  - Next cycle: state=IDLE, gnt=0, mem_valid=0, busy=0, last_ptr=sel.
  - Every grant is followed by exactly one IDLE cycle, so back-to-back accesses by different requesters are 1 cycle apart.
- mem_done while in IDLE is ignored. No state change and no error.
- Latency: req rising in IDLE gives gnt at the next edge (1 cycle).
- Fairness: a requester that is continuously requesting is granted within NREQ grants.
- A single requester holding req high is re-granted after each 1-cycle IDLE gap.
- sel always equals the index of the single set bit of gnt whenever gnt!=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to GRANT and increments every GRANT cycle without mem_done.
  - When the count reaches TIMEOUT, the arbiter releases exactly as on mem_done (last_ptr=sel) and pulses err_timeout=1 for that release cycle.
  - mem_done on the same cycle as the timeout takes precedence, so err_timeout stays 0.
- Undefined: no counter is built, err_timeout is constant 0, and a grant waits indefinitely.

Decomposition:
- Package arb_pkg holds:
  - state enum {IDLE, GRANT}
  - localparam ARB_MAX_REQ=8
  - the function onehot(idx, n)
- One natural sub-module: rr_pick. It is combinational: inputs req and last_ptr, outputs winner index and any_req. It implements the rotate, priority-encode, rotate-back chain.
- mem_port_arbiter contains the state register, output registers, last_ptr and the timeout counter.

Test Plan:
- Reset, then req=4'b1111 constant, mem_done pulsed 2 cycles after each grant → gnt sequence 0001, 0010, 0100, 1000, 0001; sel 0,1,2,3,0; one IDLE cycle (gnt=0) between grants.
- req=4'b0100 only, rising at cycle 5 → gnt=0100, sel=2, mem_valid=1 at cycle 6. mem_done at cycle 9 → gnt=0 at cycle 10.
- During a grant to requester 1, drop req[1] and raise req[3] → gnt stays 0010 until mem_done, then after the IDLE cycle gnt=1000.
- mem_done pulsed while IDLE with req=0 → no output changes.
- Assert rst_n=0 mid-GRANT (gnt=0100) → next edge gnt=0, busy=0. With req=1111 afterward, first grant is 0001.
- ARB_TIMEOUT_EN, TIMEOUT=10, req=0001, no mem_done → err_timeout pulses once 10 cycles after grant, and gnt drops the same cycle. Without the macro, gnt is held 50+ cycles and err_timeout stays 0.
